exec_ctrl: RTL
==============

Name: exec_ctrl

Overview:
- Run-control sequencer for the single-issue core (instruction memory → decoder → regfile/ALU).
- Owns the core's start/stop: gates the decoder's fetch request (next_instr) to instruction memory, and supports halted / run / single-step / drain.
- Shares the instruction-memory write port with an external loader; the loader may write only while the core is halted.
- Counts retired operations and flags a fault when an op_done never arrives.

Parameters:
- ADDR_W, 6, instruction-memory word address width
- DATA_W, 32, instruction word width
- TMO_CYC, 64, cycles an issued instruction may wait for op_done before a fault is raised (≥2)
- CNT_W, 16, width of the retired-instruction counter

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high reset
- run_req  in  1  level/pulse: enter continuous run
- step_req  in  1  pulse: execute exactly one instruction
- halt_req  in  1  pulse: stop after the outstanding instruction completes
- clr_fault  in  1  pulse: leave FAULT for HALTED
- store_en  in  1  loader write request
- store_address  in  ADDR_W  loader write address
- store_data  in  DATA_W  loader write data
- store_ready  out  1  loader write accepted this cycle
- dec_next_instr  in  1  fetch request from decoder
- op_done  in  1  completion pulse from regfile
- imem_next_instr  out  1  gated fetch request to instruction memory
- imem_wr_en  out  1  instruction-memory write strobe
- imem_wr_addr  out  ADDR_W  write address
- imem_wr_data  out  DATA_W  write data
- core_state  out  3  encoded FSM state
- retired_cnt  out  CNT_W  retired-instruction count
- timeout_fault  out  1  sticky while in FAULT

Behaviour:
- The interface is decided: one clock, clk; reset is asynchronous and active-high, port name reset.
- Reset values: FSM = HALTED, outstanding = 0, timeout counter = 0, retired_cnt = 0, imem_wr_en = 0, imem_wr_addr = 0, imem_wr_data = 0, timeout_fault = 0.
- Reset asserted mid-operation aborts everything immediately.
  - Any write in flight is dropped; imem_wr_en falls asynchronously.
- States:
  - HALTED = 0, RUN = 1, STEP = 2, DRAIN = 3, FAULT = 4.
  - core_state is the registered encoding.
- Request priority when more than one is asserted in a cycle: halt_req > step_req > run_req.
- HALTED:
  - store_ready = 1.
  - imem_wr_en/addr/data are registered copies of store_en/store_address/store_data (1-cycle latency).
  - run_req → RUN; step_req → STEP.
  - A store_en in the same cycle as the transition is still accepted.
- store_ready = 0 in every other state.
  - Loader writes are ignored (not queued); imem_wr_en = 0.
- Fetch gate: imem_next_instr = dec_next_instr & issue_ok (combinational).
  - issue_ok = 1 in RUN with outstanding = 0.
  - issue_ok = 1 in STEP with outstanding = 0 and no instruction yet issued in this step.
  - issue_ok = 0 otherwise.
- outstanding:
  - Set on a forwarded fetch; cleared on op_done.
  - Forwarded fetch and op_done in the same cycle: outstanding stays 1.
  - op_done while outstanding = 0: ignored, not counted.
- retired_cnt increments on each counted op_done and wraps at 2^CNT_W − 1 → 0.
- RUN:
  - halt_req → DRAIN if outstanding, else → HALTED.
- STEP:
  - Issues one instruction, then returns to HALTED on the cycle after its op_done.
  - halt_req before issue → HALTED; halt_req after issue → DRAIN.
- DRAIN:
  - No new fetches.
  - On op_done → HALTED next cycle.
- Timeout:
  - The counter increments each cycle outstanding = 1 and resets to 0 on clear.
  - Reaching TMO_CYC → FAULT: outstanding cleared, timeout_fault = 1.
  - Timeout has priority over halt_req in the same cycle.
- FAULT:
  - No fetches, no loader writes.
  - clr_fault → HALTED; all other requests are ignored.
- retired_cnt holds across halt/run; only reset clears it.

Decomposition:
- Package exec_ctrl_pkg holds:
  - the state enum typedef (3-bit);
  - localparams for the state encodings;
  - the default TMO_CYC.
- One natural sub-module, exec_tmo_cnt: the timeout counter.
  - Inputs: clk, reset, outstanding.
  - Output: expire pulse.
- The FSM, fetch gate and loader path stay in exec_ctrl.

Test Plan:
- Loader in HALTED: store_en = 1, addr = 5, data = 0x00A0_0113 → imem_wr_en = 1 next cycle with addr 5 and that data; store_ready = 1.
- Same write attempted in RUN → store_ready = 0 and no write.
- step_req with dec_next_instr held high → exactly one imem_next_instr pulse; op_done 3 cycles later → HALTED; retired_cnt = 1.
- RUN with 4 instructions; halt_req while the 3rd is outstanding → DRAIN, no 4th fetch; after op_done → HALTED; retired_cnt = 3.
- TMO_CYC = 8: issue, withhold op_done → FAULT with timeout_fault = 1 after 8 cycles.
  - A late op_done is not counted.
  - clr_fault → HALTED.
- Simultaneous run_req + halt_req in HALTED → stays HALTED.
- Reset asserted mid-RUN with outstanding = 1 → outputs reach their reset values asynchronously; retired_cnt = 0.
- retired_cnt preloaded to 0xFFFF via 65535 ops (or forced) → wraps to 0 on the next op_done.

Source files
------------

// File: rtl/exec_ctrl_pkg.sv
// exec_ctrl_pkg: the run-control state encoding and default timing constants
// shared by the run-control sequencer and its timeout counter.
package exec_ctrl_pkg;

    localparam logic [2:0] ST_HALTED = 3'd0;
    localparam logic [2:0] ST_RUN    = 3'd1;
    localparam logic [2:0] ST_STEP   = 3'd2;
    localparam logic [2:0] ST_DRAIN  = 3'd3;
    localparam logic [2:0] ST_FAULT  = 3'd4;

    typedef enum logic [2:0] {
        S_HALTED = ST_HALTED,
        S_RUN    = ST_RUN,
        S_STEP   = ST_STEP,
        S_DRAIN  = ST_DRAIN,
        S_FAULT  = ST_FAULT
    } state_e;

    // Cycles an issued instruction may wait for op_done before a fault is raised.
    localparam int TMO_CYC_DEF = 64;

endpackage

// File: rtl/exec_tmo_cnt.sv
// exec_tmo_cnt: counts consecutive cycles with an instruction outstanding and
// pulses expire on the TMO_CYC-th such cycle, so the owner enters FAULT at the
// following edge with exactly TMO_CYC cycles of waiting behind it.
module exec_tmo_cnt
    import exec_ctrl_pkg::*;
#(
    parameter int TMO_CYC = TMO_CYC_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic outstanding,
    output logic expire
);

    localparam int CW = $clog2(TMO_CYC + 1);
    localparam logic [CW-1:0] TC = CW'(TMO_CYC - 1);

    logic [CW-1:0] r_cnt;

    // Count while outstanding, clear as soon as nothing is pending; saturate at terminal count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (!outstanding) begin
            r_cnt <= '0;
        end else if (r_cnt != TC) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign expire = outstanding && (r_cnt == TC);

endmodule

// File: rtl/exec_ctrl.sv
// exec_ctrl: run-control sequencer for the single-issue core. Gates the
// decoder's fetch requests, arbitrates the instruction-memory write port with
// the loader, counts retired operations and traps missing completions.
//
//   state  | meaning
//   HALTED | core stopped, loader owns the imem write port
//   RUN    | continuous issue, one instruction outstanding at a time
//   STEP   | issue exactly one instruction, then back to HALTED
//   DRAIN  | halt requested, waiting for the outstanding op_done
//   FAULT  | op_done timed out; only clr_fault leaves
module exec_ctrl
    import exec_ctrl_pkg::*;
#(
    parameter int ADDR_W  = 6,
    parameter int DATA_W  = 32,
    parameter int TMO_CYC = TMO_CYC_DEF,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run_req,
    input  logic              step_req,
    input  logic              halt_req,
    input  logic              clr_fault,
    input  logic              store_en,
    input  logic [ADDR_W-1:0] store_address,
    input  logic [DATA_W-1:0] store_data,
    output logic              store_ready,
    input  logic              dec_next_instr,
    input  logic              op_done,
    output logic              imem_next_instr,
    output logic              imem_wr_en,
    output logic [ADDR_W-1:0] imem_wr_addr,
    output logic [DATA_W-1:0] imem_wr_data,
    output logic [2:0]        core_state,
    output logic [CNT_W-1:0]  retired_cnt,
    output logic              timeout_fault
);

    state_e            r_state;
    logic              r_out;
    logic              r_step_issued;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [DATA_W-1:0] r_wr_data;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_fault;

    logic w_issue_ok;
    logic w_fetch;
    logic w_expire;
    logic w_retire;
    logic w_out_next;

    exec_tmo_cnt #(
        .TMO_CYC (TMO_CYC)
    ) u_tmo (
        .clk         (clk),
        .reset       (reset),
        .outstanding (r_out),
        .expire      (w_expire)
    );

    // Fetch gate: only one instruction in flight, and a step issues at most once.
    always_comb begin
        w_issue_ok = 1'b0;
        if (r_state == S_RUN && !r_out) begin
            w_issue_ok = 1'b1;
        end else if (r_state == S_STEP && !r_out && !r_step_issued) begin
            w_issue_ok = 1'b1;
        end
    end

    assign w_fetch  = dec_next_instr & w_issue_ok;
    // A completion racing the timeout loses: the fault is already being taken.
    assign w_retire = op_done & r_out & ~w_expire;

    // Next outstanding flag: a new fetch can only happen while nothing is pending,
    // so a same-cycle op_done is stray and the new fetch keeps the flag set.
    always_comb begin
        w_out_next = r_out;
        if (w_expire) begin
            w_out_next = 1'b0;
        end else if (w_fetch) begin
            w_out_next = 1'b1;
        end else if (op_done) begin
            w_out_next = 1'b0;
        end
    end

    // Run-control FSM with its registered outputs, loader path and retire counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_HALTED;
            r_out         <= 1'b0;
            r_step_issued <= 1'b0;
            r_wr_en       <= 1'b0;
            r_wr_addr     <= '0;
            r_wr_data     <= '0;
            r_cnt         <= '0;
            r_fault       <= 1'b0;
        end else begin
            r_wr_en <= 1'b0;
            r_out   <= w_out_next;
            if (w_retire) begin
                r_cnt <= r_cnt + 1'b1;
            end

            case (r_state)
                S_HALTED: begin
                    r_step_issued <= 1'b0;
                    // The loader write is taken even on the cycle we leave HALTED.
                    r_wr_en <= store_en;
                    if (store_en) begin
                        r_wr_addr <= store_address;
                        r_wr_data <= store_data;
                    end
                    if (halt_req) begin
                        r_state <= S_HALTED;
                    end else if (step_req) begin
                        r_state <= S_STEP;
                    end else if (run_req) begin
                        r_state <= S_RUN;
                    end
                end

                S_RUN: begin
                    if (w_expire) begin
                        r_state <= S_FAULT;
                        r_fault <= 1'b1;
                    end else if (halt_req) begin
                        r_state <= w_out_next ? S_DRAIN : S_HALTED;
                    end
                end

                S_STEP: begin
                    if (w_fetch) begin
                        r_step_issued <= 1'b1;
                    end
                    if (w_expire) begin
                        r_state <= S_FAULT;
                        r_fault <= 1'b1;
                    end else if (halt_req) begin
                        // Before issue nothing is pending; after issue wait in DRAIN.
                        r_state <= w_out_next ? S_DRAIN : S_HALTED;
                    end else if (r_step_issued && w_retire) begin
                        r_state <= S_HALTED;
                    end
                end

                S_DRAIN: begin
                    if (w_expire) begin
                        r_state <= S_FAULT;
                        r_fault <= 1'b1;
                    end else if (!w_out_next) begin
                        r_state <= S_HALTED;
                    end
                end

                S_FAULT: begin
                    if (clr_fault) begin
                        r_state <= S_HALTED;
                        r_fault <= 1'b0;
                    end
                end

                default: begin
                    r_state <= S_HALTED;
                    r_fault <= 1'b0;
                end
            endcase
        end
    end

    assign store_ready     = (r_state == S_HALTED);
    assign imem_next_instr = w_fetch;
    assign imem_wr_en      = r_wr_en;
    assign imem_wr_addr    = r_wr_addr;
    assign imem_wr_data    = r_wr_data;
    assign core_state      = r_state;
    assign retired_cnt     = r_cnt;
    assign timeout_fault   = r_fault;

endmodule
